// File: rtl/adc_frame_ctrl.sv
// adc_frame_ctrl: paces the I2S ADC receiver handshake and ping-pongs captured
// samples into a two-bank frame buffer that the FFT drains one bank at a time.
module adc_frame_ctrl #(
   parameter int FRAME_LEN = 512,
   parameter int IDX_W     = 9
) (
   input  logic             sck,
   input  logic             rst,
   input  logic             enable,
   output logic             adc_start,
   input  logic             adc_flag,
   input  logic [31:0]      adc_data,
   output logic             adc_ack,
   output logic             bram_we,
   output logic [IDX_W:0]   bram_addr,
   output logic [31:0]      bram_wdata,
   output logic             frame_ready,
   output logic             ready_bank,
   input  logic             fft_done,
   output logic [15:0]      drop_cnt,
   output logic             overflow
);

   typedef enum logic [2:0] {IDLE, ARM, WAIT_S, WRITE, ACK_HI, ACK_LO} state_t;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic             wr_bank, rd_bank;
   logic [1:0]       full, full_nxt;
   logic             lo_wait;
   logic             capture, fill, release_bank, to_idle;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge sck) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = ARM;
         ARM:     state_nxt = WAIT_S;
         WAIT_S: begin
            if (adc_flag)     state_nxt = WRITE;
            else if (!enable) state_nxt = IDLE;
         end
         WRITE:   state_nxt = ACK_HI;
         ACK_HI:  state_nxt = ACK_LO;
         // ack stays low for at least two cycles so the receiver always sees its falling edge
         ACK_LO:  if (lo_wait && !adc_flag) state_nxt = enable ? WAIT_S : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      capture      = (state == WAIT_S) && adc_flag;
      fill         = (state == WRITE) && bram_we && (idx == IDX_LAST);
      release_bank = fft_done && full[rd_bank];
      to_idle      = (state_nxt == IDLE) && ((state == WAIT_S) || (state == ACK_LO));
      full_nxt     = full;
      if (fill)         full_nxt[wr_bank] = 1'b1;
      if (release_bank) full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         adc_start   <= 1'b0;
         adc_ack     <= 1'b0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_wdata  <= '0;
         frame_ready <= 1'b0;
         ready_bank  <= 1'b0;
         drop_cnt    <= '0;
         overflow    <= 1'b0;
         idx         <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         full        <= '0;
         lo_wait     <= 1'b0;
      end else begin
         adc_start   <= (state_nxt == ARM);
         adc_ack     <= (state_nxt == ACK_HI);
         bram_we     <= capture && !full[wr_bank];
         frame_ready <= fill;
         lo_wait     <= (state == ACK_LO);
         full        <= full_nxt;
         if (release_bank) rd_bank <= ~rd_bank;
         if (capture) begin
            bram_addr  <= {wr_bank, idx};
            bram_wdata <= adc_data;
         end
         // write/drop decision was taken at capture and is carried by bram_we
         if (state == WRITE) begin
            if (bram_we) begin
               if (fill) begin
                  idx        <= '0;
                  wr_bank    <= ~wr_bank;
                  ready_bank <= wr_bank;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end else begin
               drop_cnt <= sat_inc(drop_cnt);
               overflow <= 1'b1;
            end
         end
         if (to_idle) idx <= '0;
      end
   end

endmodule

// File: doc/adc_frame_ctrl.md
ADC_FRAME_CTRL -- requirements
Module: adc_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 512: samples per frame (power of two, 4..4096).
REQ-002 SHALL have parameter IDX_W, default 9: sample index width, log2(FRAME_LEN).
REQ-003 SHALL have port sck, input, 1: single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on sck rising edge.
REQ-005 SHALL have port enable, input, 1: level; 1 = run frame capture.
REQ-006 SHALL have port adc_start, output, 1: one-cycle pulse that arms the I2S ADC receiver.
REQ-007 SHALL have port adc_flag, input, 1: receiver sample-valid flag, held high until acknowledged.
REQ-008 SHALL have port adc_data, input, 32: receiver sample word, valid while adc_flag=1.
REQ-009 SHALL have port adc_ack, output, 1: acknowledge to receiver; its falling edge re-arms the receiver.
REQ-010 SHALL have port bram_we, output, 1: frame-buffer write strobe.
REQ-011 SHALL have port bram_addr, output, IDX_W+1: {bank, index}.
REQ-012 SHALL have port bram_wdata, output, 32: sample written.
REQ-013 SHALL have port frame_ready, output, 1: one-cycle pulse when a bank fills.
REQ-014 SHALL have port ready_bank, output, 1: bank just filled; valid with frame_ready and held until the next fill.
REQ-015 SHALL have port fft_done, input, 1: one-cycle pulse; the FFT has released the oldest full bank.
REQ-016 SHALL have port drop_cnt, output, 16: count of samples discarded, saturating at 16'hFFFF.
REQ-017 SHALL have port overflow, output, 1: sticky; set on the first dropped sample.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, WAIT_S, WRITE, ACK_HI, ACK_LO.
REQ-019 IDLE: when enable=1, SHALL go to ARM.
REQ-020 ARM: SHALL assert adc_start for exactly one cycle, then go to WAIT_S; ARM SHALL be entered only from IDLE.
REQ-021 WAIT_S: when adc_flag=1, SHALL latch adc_data and go to WRITE; otherwise it SHALL stay, or go to IDLE if enable=0.
REQ-022 WRITE, write bank not full: SHALL assert bram_we for one cycle with bram_addr={wr_bank,idx} and bram_wdata=latched sample, then increment idx.
REQ-023 WRITE, write bank full: SHALL keep bram_we=0, increment drop_cnt (saturating), set overflow, and leave idx unchanged.
REQ-024 WRITE: SHALL always go to ACK_HI next.
REQ-025 ACK_HI: SHALL drive adc_ack=1 for exactly one cycle, then go to ACK_LO.
REQ-026 ACK_LO: SHALL drive adc_ack=0 and wait until adc_flag=0.
REQ-027 ACK_LO exit: SHALL go to WAIT_S if enable=1, else to IDLE; an in-flight handshake SHALL always complete before going to IDLE.
REQ-028 Minimum sample period SHALL be 5 cycles: WAIT_S, WRITE, ACK_HI, two cycles of ACK_LO.
REQ-029 Frame fill: a write at idx=FRAME_LEN-1 SHALL wrap idx to 0, set full[wr_bank], toggle wr_bank, and pulse frame_ready with ready_bank=old wr_bank on the cycle after bram_we.
REQ-030 Bank release: fft_done SHALL clear full[rd_bank] and toggle rd_bank; fft_done with no bank full SHALL be ignored.
REQ-031 Fill and release in the same cycle SHALL both take effect.
REQ-032 Entering IDLE from ACK_LO or WAIT_S SHALL reset idx to 0, discarding a partial frame; full flags and bank pointers SHALL be kept.
REQ-033 Re-enabling SHALL re-issue adc_start through ARM.
REQ-034 adc_ack, adc_start, bram_we and frame_ready SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-035 While rst=1, state SHALL be IDLE and adc_start, adc_ack, bram_we, frame_ready, ready_bank, overflow, idx, wr_bank, rd_bank, full[1:0] and drop_cnt SHALL all be 0; bram_addr and bram_wdata SHALL be 0.
REQ-036 Reset SHALL take priority over all other inputs, including mid-handshake; after release, capture SHALL restart only via IDLE->ARM.

Verification
REQ-037 Reset then enable=1: adc_start SHALL pulse once, 1 cycle after enable is sampled; adc_ack and bram_we SHALL stay 0 until adc_flag rises.
REQ-038 With FRAME_LEN=4, feed samples 0xA0..0xA3 via the receiver model: writes SHALL go to addr 0..3; frame_ready SHALL pulse once with ready_bank=0; the next sample SHALL go to addr 4 (bank 1).
REQ-039 Fill both banks with no fft_done, then feed 3 more samples: bram_we SHALL stay 0, drop_cnt SHALL equal 3, overflow SHALL equal 1, and each sample SHALL still be acknowledged.
REQ-040 fft_done in the same cycle as the bank-1 fill pulse: full SHALL end as {1,0}, rd_bank=1 and wr_bank=0; subsequent writes SHALL go to bank 0.
REQ-041 Drop enable while in ACK_HI: the handshake SHALL complete with adc_ack 1->0 and flag clear, then IDLE; idx SHALL be 0; re-enable SHALL produce a new adc_start pulse.
REQ-042 Assert rst in WRITE with idx=2: the next cycle SHALL show all outputs 0, state IDLE, and no write issued.
